fact_host_if: RTL and testbench

//  Register-mapped host front end for the factorial accelerator; sits directly upstream of the CU/datapath pair.

---
 rtl/fact_pkg.sv | 22 ++
 rtl/fact_tmo_cnt.sv | 31 +++
 rtl/fact_host_if.sv | 144 ++++++++++++++
 tb/tb_fact_host_if.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fact_pkg.sv
// fact_pkg: shared types and constants for the factorial host front end.
package fact_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_N      = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_RESULT = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_CLR   = 1;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;
  localparam int STAT_TMO  = 3;

endpackage

// File: rtl/fact_tmo_cnt.sv
// fact_tmo_cnt: WAIT-state watchdog for fact_host_if (instantiated only when FACT_TIMEOUT_EN is defined).
// expire is high during the TIMEOUT_CYC-th consecutive enabled cycle after a clear.
module fact_tmo_cnt #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count;

  // Count enabled cycles from zero after each launch, saturating at the last count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expire = en && !clr && (count == LAST);

endmodule

// File: rtl/fact_host_if.sv
// fact_host_if: register-mapped host front end for the factorial CU/datapath pair.
// Latches n, holds go until the CU reports done, captures the result and raises a one-cycle irq.
// Optional build macro FACT_TIMEOUT_EN adds a WAIT watchdog that aborts with tmo/err set.
module fact_host_if
  import fact_pkg::*;
#(
  parameter int N_W         = 4,
  parameter int RES_W       = 32,
  parameter int MAX_N       = 12,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             re,
  input  logic [1:0]       addr,
  input  logic [31:0]      wd,
  output logic [31:0]      rd,
  output logic             go,
  output logic [N_W-1:0]   n_out,
  input  logic             done,
  input  logic [RES_W-1:0] result,
  output logic             irq
);

  localparam logic [N_W-1:0] MAX_N_V = N_W'(MAX_N);

  state_t           state;
  logic [RES_W-1:0] res_q;
  logic             done_flag;
  logic             err;
  logic             tmo;
  logic             busy;
  logic             ctrl_wr;
  logic             n_wr;
  logic             start_req;
  logic             clr_req;
  logic             n_ok;
  logic             start_ok;
  logic             tmo_expire;
  logic [31:0]      read_word;
  logic             unused_wd_bits;

  assign ctrl_wr   = we && (addr == ADDR_CTRL);
  assign n_wr      = we && (addr == ADDR_N);
  assign start_req = ctrl_wr && wd[CTRL_START];
  assign clr_req   = ctrl_wr && wd[CTRL_CLR];
  assign n_ok      = (n_out <= MAX_N_V);
  assign start_ok  = (state == IDLE) && start_req && n_ok;
  assign busy      = (state == WAIT);

  assign unused_wd_bits = ^wd[31:N_W];

`ifdef FACT_TIMEOUT_EN
  fact_tmo_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_tmo_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_ok),
    .en    (busy),
    .expire(tmo_expire)
  );
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign tmo_expire = 1'b0;
`endif

  // Read mux: STATUS and RESULT are readable, the write-only addresses read as zero
  always_comb begin
    read_word = '0;
    case (addr)
      ADDR_STATUS: begin
        read_word[STAT_BUSY] = busy;
        read_word[STAT_DONE] = done_flag;
        read_word[STAT_ERR]  = err;
        read_word[STAT_TMO]  = tmo;
      end
      ADDR_RESULT: read_word = 32'(res_q);
      default:     read_word = '0;
    endcase
  end

  // Register file, launch/capture FSM and registered read port; a CLR is applied before START or capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      go        <= 1'b0;
      n_out     <= '0;
      rd        <= '0;
      irq       <= 1'b0;
      res_q     <= '0;
      done_flag <= 1'b0;
      err       <= 1'b0;
      tmo       <= 1'b0;
    end else begin
      irq <= 1'b0;
      if (re) begin
        rd <= read_word;
      end
      if (clr_req) begin
        done_flag <= 1'b0;
        err       <= 1'b0;
        tmo       <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (n_wr) begin
            n_out <= wd[N_W-1:0];
          end
          if (start_req) begin
            if (n_ok) begin
              state     <= WAIT;
              go        <= 1'b1;
              done_flag <= 1'b0;
              err       <= 1'b0;
              tmo       <= 1'b0;
            end else begin
              err <= 1'b1;
              irq <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (done) begin
            res_q     <= result;
            go        <= 1'b0;
            done_flag <= 1'b1;
            irq       <= 1'b1;
            state     <= IDLE;
          end else if (tmo_expire) begin
            go    <= 1'b0;
            tmo   <= 1'b1;
            err   <= 1'b1;
            irq   <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fact_host_if.sv
// tb_fact_host_if: self-checking bench for fact_host_if with a behavioural CU/datapath
// (done 2*n+3 cycles after go, result n!) and a transaction-level host register model.
// Build with FACT_TIMEOUT_EN defined to also exercise the WAIT watchdog.
module tb_fact_host_if;
  import fact_pkg::*;

  logic        clk;
  logic        rst;
  logic        we;
  logic        re;
  logic [1:0]  addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        go;
  logic [3:0]  n_out;
  logic        done;
  logic [31:0] result;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int go_cnt = 0;
  int irq_cnt = 0;
  int cu_cnt = 0;
  bit cu_stall = 0;
  bit spurious_en = 0;

  bit          m_busy;
  logic [3:0]  m_n;
  logic [31:0] m_res;
  logic [31:0] m_rd;
  bit          m_done;
  bit          m_err;
  bit          m_tmo;
  bit          m_irq;
  int          m_wait;

  fact_host_if dut (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .re    (re),
    .addr  (addr),
    .wd    (wd),
    .rd    (rd),
    .go    (go),
    .n_out (n_out),
    .done  (done),
    .result(result),
    .irq   (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] fact(input int k);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 2; i <= k; i++) p = p * 32'(i);
    return p;
  endfunction

  function automatic logic [31:0] model_status();
    return 32'((m_tmo ? 8 : 0) + (m_err ? 4 : 0) + (m_done ? 2 : 0) + (m_busy ? 1 : 0));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Advance the host model by one clock edge using the inputs present at that edge
  task automatic model_step();
    if (!rst) begin
      m_busy = 0; m_n = 4'd0; m_res = 32'd0; m_rd = 32'd0;
      m_done = 0; m_err = 0; m_tmo = 0; m_irq = 0; m_wait = 0;
    end else begin
      m_irq = 0;
      if (re) m_rd = (addr == ADDR_STATUS) ? model_status() : (addr == ADDR_RESULT) ? m_res : 32'd0;
      if (we && addr == ADDR_CTRL && wd[1]) begin
        m_done = 0; m_err = 0; m_tmo = 0;
      end
      if (m_busy) begin
        if (done) begin
          m_res = result; m_busy = 0; m_done = 1; m_irq = 1;
        end else begin
          m_wait++;
`ifdef FACT_TIMEOUT_EN
          if (m_wait >= 64) begin
            m_busy = 0; m_tmo = 1; m_err = 1; m_irq = 1;
          end
`endif
        end
      end else begin
        if (we && addr == ADDR_N) m_n = wd[3:0];
        if (we && addr == ADDR_CTRL && wd[0]) begin
          if (int'(m_n) > 12) begin
            m_err = 1; m_irq = 1;
          end else begin
            m_busy = 1; m_wait = 0; m_done = 0; m_err = 0; m_tmo = 0;
          end
        end
      end
    end
  endtask

  // Compare process: every edge, update the model then check all DUT outputs just after the edge
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      checkOutput("go", 32'(go), 32'(m_busy));
      checkOutput("n_out", 32'(n_out), 32'(m_n));
      checkOutput("irq", 32'(irq), 32'(m_irq));
      checkOutput("rd", rd, m_rd);
      if (go === 1'b1) go_cnt++;
      if (irq === 1'b1) irq_cnt++;
    end
  end

  // Behavioural CU/datapath: raise done 2*n+3 cycles into a go request, optionally spurious done while idle
  initial begin
    done = 1'b0;
    result = 32'd0;
    forever begin
      @(negedge clk);
      if (go !== 1'b1) begin
        cu_cnt = 0;
        done = 1'b0;
        if (spurious_en && $urandom_range(0, 7) == 0) begin
          done = 1'b1;
          result = $urandom;
        end
      end else begin
        done = 1'b0;
        result = $urandom;
        cu_cnt++;
        if (!cu_stall && cu_cnt == 2 * int'(n_out) + 3) begin
          done = 1'b1;
          result = fact(int'(n_out));
        end
      end
    end
  end

  task automatic applyStimulus(input logic w, input logic r, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    we = w; re = r; addr = a; wd = d;
    @(posedge clk);
    #2;
    we = 1'b0; re = 1'b0;
  endtask

  task automatic readReg(input logic [1:0] a, output logic [31:0] v);
    applyStimulus(1'b0, 1'b1, a, $urandom);
    v = rd;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 2'(i), 32'd0);
  endtask

  task automatic waitIdle(input int budget, input string name);
    int n;
    n = 0;
    while (go === 1'b1 && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    checkOutput(name, 32'(go), 32'd0);
  endtask

  task automatic pulseReset();
    rst = 1'b0;
    #1;
    checkOutput("rstpulse_go", 32'(go), 32'd0);
    checkOutput("rstpulse_irq", 32'(irq), 32'd0);
    checkOutput("rstpulse_rd", rd, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main_seq
    logic [31:0] v;
    int kind;
    rst = 1'b0; we = 1'b0; re = 1'b0; addr = 2'd0; wd = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_go", 32'(go), 32'd0);
    checkOutput("reset_rd", rd, 32'd0);
    checkOutput("reset_irq", 32'(irq), 32'd0);
    checkOutput("reset_n_out", 32'(n_out), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    readReg(ADDR_STATUS, v); checkOutput("reset_status", v, 32'd0);
    readReg(ADDR_RESULT, v); checkOutput("reset_result", v, 32'd0);

    $display("[TB] n=5 factorial");
    applyStimulus(1'b1, 1'b0, ADDR_N, 32'd5);
    go_cnt = 0; irq_cnt = 0;
    applyStimulus(1'b1, 1'b0, ADDR_CTRL, 32'h1);
    checkOutput("n5_go_high", 32'(go), 32'd1);
    waitIdle(100, "n5_go_drop");
    checkOutput("n5_go_cycles", 32'(go_cnt), 32'd13);
    readReg(ADDR_STATUS, v); checkOutput("n5_status", v, 32'h2);
    readReg(ADDR_RESULT, v); checkOutput("n5_result", v, 32'd120);
    checkOutput("n5_irq_count", 32'(irq_cnt), 32'd1);

    $display("[TB] mid-run reset");
    pulseReset();
    readReg(ADDR_STATUS, v); checkOutput("midrst_status", v, 32'd0);
    readReg(ADDR_RESULT, v); checkOutput("midrst_result", v, 32'd0);

    $display("[TB] n=13 rejected");
    applyStimulus(1'b1, 1'b0, ADDR_N, 32'd13);
    go_cnt = 0; irq_cnt = 0;
    applyStimulus(1'b1, 1'b0, ADDR_CTRL, 32'h1);
    idleCycles(4);
    checkOutput("n13_go_cycles", 32'(go_cnt), 32'd0);
    checkOutput("n13_irq_count", 32'(irq_cnt), 32'd1);
    checkOutput("n13_n_out", 32'(n_out), 32'd13);
    readReg(ADDR_STATUS, v); checkOutput("n13_status", v, 32'h4);
    applyStimulus(1'b1, 1'b0, ADDR_CTRL, 32'h2);
    readReg(ADDR_STATUS, v); checkOutput("n13_clr_status", v, 32'h0);

    $display("[TB] n=12 with writes during WAIT");
    applyStimulus(1'b1, 1'b0, ADDR_N, 32'd12);
    applyStimulus(1'b1, 1'b0, ADDR_CTRL, 32'h1);
    applyStimulus(1'b1, 1'b0, ADDR_N, 32'd3);
    applyStimulus(1'b1, 1'b0, ADDR_CTRL, 32'h1);
    checkOutput("n12_n_out_held", 32'(n_out), 32'd12);
    readReg(ADDR_STATUS, v); checkOutput("n12_status_busy", v, 32'h1);
    waitIdle(100, "n12_go_drop");
    checkOutput("n12_n_out_end", 32'(n_out), 32'd12);
    readReg(ADDR_RESULT, v); checkOutput("n12_result", v, 32'd479001600);
    readReg(ADDR_STATUS, v); checkOutput("n12_status", v, 32'h2);

`ifdef FACT_TIMEOUT_EN
    $display("[TB] watchdog expiry");
    cu_stall = 1;
    applyStimulus(1'b1, 1'b0, ADDR_N, 32'd5);
    go_cnt = 0; irq_cnt = 0;
    applyStimulus(1'b1, 1'b0, ADDR_CTRL, 32'h1);
    waitIdle(200, "tmo_go_drop");
    checkOutput("tmo_go_cycles", 32'(go_cnt), 32'd64);
    checkOutput("tmo_irq_count", 32'(irq_cnt), 32'd1);
    readReg(ADDR_STATUS, v); checkOutput("tmo_status", v, 32'hC);
    readReg(ADDR_RESULT, v); checkOutput("tmo_result", v, 32'd479001600);
    cu_stall = 0;
    applyStimulus(1'b1, 1'b0, ADDR_CTRL, 32'h2);
`endif

    $display("[TB] reset during WAIT");
    applyStimulus(1'b1, 1'b0, ADDR_N, 32'd7);
    applyStimulus(1'b1, 1'b0, ADDR_CTRL, 32'h1);
    idleCycles(4);
    checkOutput("wrst_go_before", 32'(go), 32'd1);
    #1;
    pulseReset();
    go_cnt = 0; irq_cnt = 0;
    idleCycles(8);
    checkOutput("wrst_irq_count", 32'(irq_cnt), 32'd0);
    checkOutput("wrst_go_cycles", 32'(go_cnt), 32'd0);
    readReg(ADDR_STATUS, v); checkOutput("wrst_status", v, 32'd0);

    $display("[TB] random traffic");
    spurious_en = 1;
    for (int i = 0; i < 1500; i++) begin
      kind = int'($urandom_range(0, 19));
      if (kind <= 4) begin
        applyStimulus(1'b1, 1'b0, ADDR_N, $urandom);
      end else if (kind <= 7) begin
        applyStimulus(1'b1, 1'b0, ADDR_CTRL, $urandom);
      end else if (kind <= 12) begin
        applyStimulus(1'b0, 1'b1, 2'($urandom_range(0, 3)), $urandom);
      end else if (kind <= 14) begin
        applyStimulus(1'b1, 1'b1, 2'($urandom_range(0, 3)), $urandom);
      end else if (kind == 15 && $urandom_range(0, 9) == 0) begin
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end else begin
        applyStimulus(1'b0, 1'b0, 2'($urandom_range(0, 3)), $urandom);
      end
    end
    spurious_en = 0;
    idleCycles(40);
    waitIdle(100, "final_go_drop");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
